// File: rtl/counter_cmd_seq.sv
// counter_cmd_seq: command sequencer driving an 8-bit up/down load counter.
// Buffers LOAD/UP/DOWN/HOLD commands in a FIFO and replays each one as
// registered, cycle-accurate counter controls.
// Optional build macro: CNT_SEQ_SHADOW_EN adds a shadow counter model that
// compares against the real counter output and raises a sticky mismatch flag.
module counter_cmd_seq #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_arg,
  input  logic       abort,
  output logic       ld_cnt_,
  output logic       updn_cnt,
  output logic       count_enb,
  output logic [7:0] data_in,
  output logic       busy,
  output logic       done
`ifdef CNT_SEQ_SHADOW_EN
  ,
  input  logic [7:0] data_out,
  output logic [7:0] shadow_cnt,
  output logic       mismatch
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_HOLD = 2'b11} op_t;

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, last_cycle, launch;
  op_t         head_op;
  logic [7:0]  head_arg;
  state_t      state;
  logic [7:0]  rem;

  // FIFO status, handshake and command-launch decisions
  always_comb begin
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    cmd_ready  = !full && !abort;
    push       = cmd_valid && cmd_ready;
    head_op    = op_t'(mem[rd_ptr[AW-1:0]][9:8]);
    head_arg   = mem[rd_ptr[AW-1:0]][7:0];
    // rem of 0 or 1 both mark the final cycle of a RUN command
    last_cycle = (state == S_LOAD) || ((state == S_RUN) && (rem <= 8'd1));
    launch     = !empty && ((state == S_IDLE) || last_cycle);
    busy       = (state != S_IDLE) || !empty;
  end

  // FIFO storage; contents need no reset since pointers gate validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_arg};
  end

  // FIFO pointers; abort flushes
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (launch) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sequencer FSM with registered counter controls
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= S_IDLE;
      rem       <= '0;
      ld_cnt_   <= 1'b1;
      updn_cnt  <= 1'b1;
      count_enb <= 1'b0;
      data_in   <= '0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      rem       <= '0;
      ld_cnt_   <= 1'b1;
      count_enb <= 1'b0;
      done      <= 1'b0;
    end else if (launch) begin
      if (head_op == OP_LOAD) begin
        state     <= S_LOAD;
        ld_cnt_   <= 1'b0;
        data_in   <= head_arg;
        count_enb <= 1'b0;
        done      <= 1'b1;
      end else begin
        state     <= S_RUN;
        rem       <= head_arg;
        ld_cnt_   <= 1'b1;
        done      <= (head_arg <= 8'd1);
        count_enb <= (head_op != OP_HOLD) && (head_arg != 8'd0);
        if ((head_op == OP_UP) && (head_arg != 8'd0))   updn_cnt <= 1'b1;
        if ((head_op == OP_DOWN) && (head_arg != 8'd0)) updn_cnt <= 1'b0;
      end
    end else if ((state == S_RUN) && !last_cycle) begin
      rem  <= rem - 8'd1;
      done <= (rem == 8'd2);
    end else if (last_cycle) begin
      state     <= S_IDLE;
      ld_cnt_   <= 1'b1;
      count_enb <= 1'b0;
      done      <= 1'b0;
    end
  end

`ifdef CNT_SEQ_SHADOW_EN
  logic armed;

  // Shadow counter tracks emitted controls; checks begin after the first load
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      shadow_cnt <= '0;
      mismatch   <= 1'b0;
      armed      <= 1'b0;
    end else if (abort) begin
      mismatch <= 1'b0;
      armed    <= 1'b0;
    end else begin
      if (!ld_cnt_) begin
        shadow_cnt <= data_in;
        armed      <= 1'b1;
      end else if (count_enb) begin
        shadow_cnt <= updn_cnt ? shadow_cnt + 8'd1 : shadow_cnt - 8'd1;
      end
      if (armed && (data_out != shadow_cnt)) mismatch <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Directed bench for counter_cmd_seq; optional shadow section under CNT_SEQ_SHADOW_EN.
module tb_counter_cmd_seq;

  logic       clk = 1'b0;
  logic       rst_;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       abort;
  logic       ld_cnt_;
  logic       updn_cnt;
  logic       count_enb;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
`ifdef CNT_SEQ_SHADOW_EN
  logic [7:0] data_out;
  logic [7:0] shadow_cnt;
  logic       mismatch;
  logic [7:0] cnt_model;
  logic       force_en;
  logic [7:0] force_val;
`endif

  int total = 0;
  int bad   = 0;
  int n;

  localparam logic [1:0] LOAD = 2'b00, UP = 2'b01, DOWN = 2'b10, HOLD = 2'b11;

  counter_cmd_seq #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .abort     (abort),
    .ld_cnt_   (ld_cnt_),
    .updn_cnt  (updn_cnt),
    .count_enb (count_enb),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done)
`ifdef CNT_SEQ_SHADOW_EN
    ,
    .data_out  (data_out),
    .shadow_cnt(shadow_cnt),
    .mismatch  (mismatch)
`endif
  );

  always #5 clk = ~clk;

`ifdef CNT_SEQ_SHADOW_EN
  // Behavioural stand-in for the real counter
  always_ff @(posedge clk) begin
    if (!ld_cnt_)      cnt_model <= data_in;
    else if (count_enb) cnt_model <= updn_cnt ? cnt_model + 8'd1 : cnt_model - 8'd1;
  end
  assign data_out = force_en ? force_val : cnt_model;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ = 1'b0; cmd_valid = 1'b0; cmd_op = LOAD; cmd_arg = 8'h00; abort = 1'b0;
`ifdef CNT_SEQ_SHADOW_EN
    force_en = 1'b0; force_val = 8'h00;
`endif
    step(); step();
    check("rst_ld", ld_cnt_, 1);
    check("rst_updn", updn_cnt, 1);
    check("rst_enb", count_enb, 0);
    check("rst_data", data_in, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_ = 1'b1;
    check("rst_ready", cmd_ready, 1);
    step();

    // LOAD A5
    cmd_valid = 1'b1; cmd_op = LOAD; cmd_arg = 8'hA5;
    step();                       // E: push
    cmd_valid = 1'b0;
    check("ld_busy_q", busy, 1);
    check("ld_pre_ld", ld_cnt_, 1);
    step();                       // E+1
    check("ld_ld", ld_cnt_, 0);
    check("ld_data", data_in, 8'hA5);
    check("ld_done", done, 1);
    check("ld_enb", count_enb, 0);
    step();                       // E+2
    check("ld_idle_ld", ld_cnt_, 1);
    check("ld_idle_done", done, 0);
    check("ld_idle_data", data_in, 8'hA5);
    check("ld_idle_busy", busy, 0);

    // UP(3) then DOWN(2) back to back
    cmd_valid = 1'b1; cmd_op = UP; cmd_arg = 8'd3;
    step();                       // E: push UP
    cmd_op = DOWN; cmd_arg = 8'd2;
    step();                       // E+1: push DOWN, launch UP
    cmd_valid = 1'b0;
    check("ud_c1_enb", count_enb, 1);
    check("ud_c1_updn", updn_cnt, 1);
    check("ud_c1_done", done, 0);
    step();
    check("ud_c2_enb", count_enb, 1);
    check("ud_c2_done", done, 0);
    step();
    check("ud_c3_updn", updn_cnt, 1);
    check("ud_c3_done", done, 1);
    step();
    check("ud_c4_enb", count_enb, 1);
    check("ud_c4_updn", updn_cnt, 0);
    check("ud_c4_done", done, 0);
    step();
    check("ud_c5_updn", updn_cnt, 0);
    check("ud_c5_done", done, 1);
    step();
    check("ud_idle_enb", count_enb, 0);
    check("ud_idle_done", done, 0);
    check("ud_idle_busy", busy, 0);

    // Fill the FIFO while HOLD(20) runs
    cmd_valid = 1'b1; cmd_op = HOLD; cmd_arg = 8'd20;
    step();                       // E
    cmd_op = HOLD; cmd_arg = 8'd0;
    step();                       // E+1: push A, launch HOLD(20)
    check("fill_hold_enb", count_enb, 0);
    cmd_op = UP; cmd_arg = 8'd1;
    step();                       // E+2: push B
    cmd_op = HOLD; cmd_arg = 8'd0;
    step();                       // E+3: push C
    step();                       // E+4: push D
    check("fill_ready0", cmd_ready, 0);
    check("fill_busy", busy, 1);
    cmd_op = DOWN; cmd_arg = 8'd1;
    n = 0;
    while (!cmd_ready && n < 40) begin
      step();
      n++;
    end
    check("fill_wait", n[7:0], 8'd17);
    check("fill_h0_done", done, 1);
    check("fill_h0_enb", count_enb, 0);
    step();                       // push 5th, launch UP(1)
    cmd_valid = 1'b0;
    check("fill_up1_enb", count_enb, 1);
    check("fill_up1_done", done, 1);
    step();
    check("fill_c_done", done, 1);
    check("fill_c_enb", count_enb, 0);
    check("fill_c_updn", updn_cnt, 1);
    step();
    check("fill_d_done", done, 1);
    step();
    check("fill_5th_enb", count_enb, 1);
    check("fill_5th_updn", updn_cnt, 0);
    check("fill_5th_done", done, 1);
    step();
    check("fill_idle_busy", busy, 0);

    // Abort during UP(50) with two queued and a concurrent push
    cmd_valid = 1'b1; cmd_op = UP; cmd_arg = 8'd50;
    step();
    cmd_op = UP; cmd_arg = 8'd5;
    step();
    cmd_op = DOWN; cmd_arg = 8'd5;
    step();
    cmd_valid = 1'b0;
    step();
    check("ab_running", count_enb, 1);
    abort = 1'b1; cmd_valid = 1'b1; cmd_op = HOLD; cmd_arg = 8'd7;
    #1;
    check("ab_ready0", cmd_ready, 0);
    step();
    abort = 1'b0; cmd_valid = 1'b0;
    check("ab_enb", count_enb, 0);
    check("ab_ld", ld_cnt_, 1);
    check("ab_done", done, 0);
    check("ab_busy", busy, 0);
    step(); step();
    check("ab_drop_busy", busy, 0);
    check("ab_drop_enb", count_enb, 0);
    check("ab_ready1", cmd_ready, 1);

    // Asynchronous reset mid-run
    cmd_valid = 1'b1; cmd_op = UP; cmd_arg = 8'd10;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    check("mr_running", count_enb, 1);
    #2 rst_ = 1'b0;
    #1;
    check("mr_ld", ld_cnt_, 1);
    check("mr_enb", count_enb, 0);
    check("mr_busy", busy, 0);
    step();
    rst_ = 1'b1;
    check("mr_ready", cmd_ready, 1);
    step();
    check("mr_idle_enb", count_enb, 0);
    check("mr_idle_busy", busy, 0);

`ifdef CNT_SEQ_SHADOW_EN
    // Shadow: LOAD 255 then UP(1) wraps to 0; forced divergence is sticky until abort
    cmd_valid = 1'b1; cmd_op = LOAD; cmd_arg = 8'd255;
    step();
    cmd_op = UP; cmd_arg = 8'd1;
    step();
    cmd_valid = 1'b0;
    step(); step();
    check("sh_wrap", shadow_cnt, 8'h00);
    check("sh_ok", mismatch, 0);
    force_en = 1'b1; force_val = 8'h01;
    step();
    check("sh_mis", mismatch, 1);
    force_en = 1'b0;
    step();
    check("sh_sticky", mismatch, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("sh_clr", mismatch, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
